gbe_multi_ch_packetizer: RTL

Parametrised multi-channel transmit packetizer for the 10GbE fabric interface. It buffers N_CH independent 64-bit sample streams in per-channel FIFOs. It arbitrates round-robin among channels holding a full payload and emits framed packets onto the core's tx_* interface: one header word, PAYLOAD_WORDS data words, then end_of_frame. Each packet carries its own per-channel destination IP/port and sequence number, and the block honours tx_afull back-pressure mid-frame.

---
 rtl/gbe_pkt_pkg.sv | 18 +
 rtl/gbe_pkt_fifo.sv | 50 +++++
 rtl/gbe_multi_ch_packetizer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/gbe_pkt_pkg.sv
// Shared types and helpers for the multi-channel GbE transmit packetizer.
//   pkt_state_e : framing FSM states
//   SEQ_FLD_W / CH_FLD_W : header field widths (header = {seq, channel})
//   hdr_word()  : builds the 64-bit header word
package gbe_pkt_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} pkt_state_e;

  localparam int DATA_W    = 64;
  localparam int SEQ_FLD_W = 48;
  localparam int CH_FLD_W  = 16;

  function automatic logic [DATA_W-1:0] hdr_word(input logic [SEQ_FLD_W-1:0] seq,
                                                 input logic [CH_FLD_W-1:0]  ch);
    return {seq, ch};
  endfunction

endpackage

// File: rtl/gbe_pkt_fifo.sv
// Single-clock first-word-fall-through FIFO, 64-bit words, depth 2**AW.
//   wr_en/wr_data : write port; a write to a full FIFO is accepted only when a
//                   read happens in the same cycle
//   rd_en/rd_data : rd_data always shows the head word; rd_en pops it
//   count/full/empty : occupancy status
module gbe_pkt_fifo
  import gbe_pkt_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2**AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic              do_rd, do_wr;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/gbe_multi_ch_packetizer.sv
// Multi-channel transmit packetizer. Buffers N_CH 64-bit streams in per-channel
// FWFT FIFOs, picks a channel holding a full payload round-robin, and emits
// {header, PAYLOAD_WORDS data words} with end_of_frame on the last word.
//   in_valid/in_data          : per-channel write ports (channel c at [64c+:64])
//   ch_dest_ip/ch_dest_port   : per-channel destination, latched at packet start
//   overflow_clr/ch_overflow  : sticky per-channel write-to-full flags
//   tx_afull                  : core back-pressure, stalls mid-frame
//   tx_*                      : registered framed output
//   pkt_count                 : completed packets, wraps
module gbe_multi_ch_packetizer
  import gbe_pkt_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int FIFO_AW       = 9,
  parameter int PAYLOAD_WORDS = 128,
  parameter int SEQ_W         = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [64*N_CH-1:0]   in_data,
  input  logic [32*N_CH-1:0]   ch_dest_ip,
  input  logic [16*N_CH-1:0]   ch_dest_port,
  input  logic                 overflow_clr,
  output logic [N_CH-1:0]      ch_overflow,
  input  logic                 tx_afull,
  output logic                 tx_valid,
  output logic [63:0]          tx_data,
  output logic                 tx_end_of_frame,
  output logic [31:0]          tx_dest_ip,
  output logic [15:0]          tx_dest_port,
  output logic [31:0]          pkt_count
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WC_W = $clog2(PAYLOAD_WORDS + 1);

  pkt_state_e                        state, state_n;
  logic [CH_W-1:0]                   rr_ptr, rr_n, pick;  // rr_ptr doubles as the active channel
  logic [WC_W-1:0]                   wcnt, wcnt_n;
  logic [N_CH-1:0][SEQ_W-1:0]        seq;
  logic [N_CH-1:0][FIFO_AW:0]        fifo_cnt;
  logic [N_CH-1:0][DATA_W-1:0]       fifo_dout;
  logic [N_CH-1:0]                   fifo_full, fifo_empty, pop, elig, ovf_new;
  logic                              found, start, acc, acc_eof, last;
  logic [DATA_W-1:0]                 acc_data;
  int                                idx;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    gbe_pkt_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (in_valid[c]),
      .wr_data(in_data[64*c +: 64]),
      .rd_en  (pop[c]),
      .rd_data(fifo_dout[c]),
      .count  (fifo_cnt[c]),
      .full   (fifo_full[c]),
      .empty  (fifo_empty[c])
    );
    assign elig[c] = ~fifo_empty[c] & (fifo_cnt[c] >= (FIFO_AW+1)'(PAYLOAD_WORDS));
  end

  // A same-cycle pop frees a slot, so only a write with no pop is dropped.
  assign ovf_new = in_valid & fifo_full & ~pop;

  // Round-robin: first eligible channel after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(rr_ptr) + i) % N_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_n  = state;
    rr_n     = rr_ptr;
    wcnt_n   = wcnt;
    pop      = '0;
    start    = 1'b0;
    acc      = 1'b0;
    acc_eof  = 1'b0;
    acc_data = '0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          start   = 1'b1;
          rr_n    = pick;
          state_n = HEADER;
        end
      end
      HEADER: begin
        if (!tx_afull) begin
          acc      = 1'b1;
          acc_data = hdr_word(SEQ_FLD_W'(seq[rr_ptr]), CH_FLD_W'(rr_ptr));
          wcnt_n   = '0;
          state_n  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!tx_afull) begin
          acc         = 1'b1;
          pop[rr_ptr] = 1'b1;
          acc_data    = fifo_dout[rr_ptr];
          wcnt_n      = wcnt + WC_W'(1);
          if (wcnt == WC_W'(PAYLOAD_WORDS - 1)) begin
            acc_eof = 1'b1;
            last    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      rr_ptr          <= CH_W'(N_CH - 1);
      wcnt            <= '0;
      seq             <= '0;
      ch_overflow     <= '0;
      pkt_count       <= '0;
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      tx_end_of_frame <= 1'b0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
    end else begin
      state           <= state_n;
      rr_ptr          <= rr_n;
      wcnt            <= wcnt_n;
      tx_valid        <= acc;
      tx_data         <= acc_data;
      tx_end_of_frame <= acc_eof;
      if (start) begin
        tx_dest_ip   <= ch_dest_ip[32*pick +: 32];
        tx_dest_port <= ch_dest_port[16*pick +: 16];
      end
      if (last) begin
        seq[rr_ptr] <= seq[rr_ptr] + SEQ_W'(1);
        pkt_count   <= pkt_count + 32'd1;
      end
      // A flag raised in the clearing cycle survives the clear.
      ch_overflow <= overflow_clr ? ovf_new : (ch_overflow | ovf_new);
    end
  end

endmodule
